mem_wb_skid_stage: RTL and testbench



---
 rtl/arm_pipe_pkg.sv | 20 ++
 rtl/pipe_skid_slice.sv | 84 ++++++++
 rtl/mem_wb_skid_stage.sv | 99 +++++++++
 tb/tb_mem_wb_skid_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared types and defaults for the ARM core pipeline stages.
package arm_pipe_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DST_W  = 4;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_read_en;
    logic [DEF_DATA_W-1:0] alu_res;
    logic [DEF_DATA_W-1:0] data_mem;
    logic [DEF_DST_W-1:0]  dst;
  } mem_wb_payload_t;

  // Flattened width of a MEM->WB payload for arbitrary data/destination widths.
  function automatic int unsigned payload_width(int unsigned data_w, int unsigned dst_w);
    return 2 + 2 * data_w + dst_w;
  endfunction

endpackage

// File: rtl/pipe_skid_slice.sv
// Generic two-entry skid buffer: main entry drives the outputs, skid entry absorbs one beat so
// in_ready never depends on out_ready.
module pipe_skid_slice #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  input  logic             freeze,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic [Width-1:0] m_data_q, m_data_d;
  logic [Width-1:0] s_data_q, s_data_d;
  logic             accept, pop;

  assign in_ready  = ~s_valid_q & ~freeze & ~flush;
  assign accept    = in_valid & in_ready;
  assign pop       = m_valid_q & out_ready & ~freeze;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;

  // Freeze needs no branch of its own: it already masks both accept and pop.
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_data_d  = '0;
      s_data_d  = '0;
    end else begin
      case ({m_valid_q, s_valid_q})
        2'b00: begin
          if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
          end
        end
        2'b10: begin
          if (accept && pop) begin
            m_data_d = in_data;
          end else if (pop) begin
            m_valid_d = 1'b0;
          end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
          end
        end
        2'b11: begin
          if (pop) begin
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline stage: skid-buffered handshake, write-back value mux and a saturating
// back-pressure counter.
module mem_wb_skid_stage
  import arm_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DST_W  = DEF_DST_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_read_en,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_data_mem,
  input  logic [DST_W-1:0]  in_dst,
  input  logic              freeze,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_read_en,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_data_mem,
  output logic [DST_W-1:0]  out_dst,
  output logic [DATA_W-1:0] out_wb_value,
  input  logic              clear_stats,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned PayloadW = payload_width(DATA_W, DST_W);

  // Same field order as mem_wb_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic              wb_en;
    logic              mem_read_en;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] data_mem;
    logic [DST_W-1:0]  dst;
  } entry_t;

  entry_t                in_entry;
  entry_t                head;
  logic [PayloadW-1:0]   head_bits;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  assign in_entry = '{
    wb_en:       in_wb_en,
    mem_read_en: in_mem_read_en,
    alu_res:     in_alu_res,
    data_mem:    in_data_mem,
    dst:         in_dst
  };

  pipe_skid_slice #(
    .Width (PayloadW)
  ) u_slice (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .freeze    (freeze),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_bits)
  );

  assign head            = entry_t'(head_bits);
  assign out_wb_en       = head.wb_en & out_valid;
  assign out_mem_read_en = head.mem_read_en;
  assign out_alu_res     = head.alu_res;
  assign out_data_mem    = head.data_mem;
  assign out_dst         = head.dst;
  assign out_wb_value    = head.mem_read_en ? head.data_mem : head.alu_res;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clear_stats) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Self-checking bench for mem_wb_skid_stage: directed scenarios then random traffic, all
// compared against a queue-based reference model.
module tb_mem_wb_skid_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready2;
  logic        in_wb_en = 1'b0, in_mem_read_en = 1'b0;
  logic [31:0] in_alu_res = '0, in_data_mem = '0;
  logic [3:0]  in_dst = '0;
  logic        freeze = 1'b0, flush = 1'b0, out_ready = 1'b0, clear_stats = 1'b0;
  logic        out_valid, out_wb_en, out_mem_read_en;
  logic [31:0] out_alu_res, out_data_mem, out_wb_value;
  logic [3:0]  out_dst;
  logic [15:0] stall_cnt;
  logic        out_valid2, out_wb_en2, out_mem_read_en2;
  logic [31:0] out_alu_res2, out_data_mem2, out_wb_value2;
  logic [3:0]  out_dst2;
  logic [1:0]  stall_cnt2;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic        wb_en;
    logic        mrd;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [3:0]  dst;
  } ent_t;

  ent_t        q[$];
  int unsigned cnt16 = 0;
  int unsigned cnt2 = 0;
  bit          clean = 1'b1;

  always #5 clk = ~clk;

  mem_wb_skid_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_wb_en(in_wb_en),
    .in_mem_read_en(in_mem_read_en), .in_alu_res(in_alu_res), .in_data_mem(in_data_mem),
    .in_dst(in_dst), .freeze(freeze), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_wb_en(out_wb_en), .out_mem_read_en(out_mem_read_en),
    .out_alu_res(out_alu_res), .out_data_mem(out_data_mem), .out_dst(out_dst),
    .out_wb_value(out_wb_value), .clear_stats(clear_stats), .stall_cnt(stall_cnt)
  );

  mem_wb_skid_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_wb_en(in_wb_en),
    .in_mem_read_en(in_mem_read_en), .in_alu_res(in_alu_res), .in_data_mem(in_data_mem),
    .in_dst(in_dst), .freeze(freeze), .flush(flush), .out_valid(out_valid2),
    .out_ready(out_ready), .out_wb_en(out_wb_en2), .out_mem_read_en(out_mem_read_en2),
    .out_alu_res(out_alu_res2), .out_data_mem(out_data_mem2), .out_dst(out_dst2),
    .out_wb_value(out_wb_value2), .clear_stats(clear_stats), .stall_cnt(stall_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit   v;
    ent_t h;
    v = (q.size() > 0);
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("dut2_out_valid", 64'(out_valid2), 64'(v));
    chk("stall_cnt", 64'(stall_cnt), 64'(cnt16));
    chk("stall_cnt_w2", 64'(stall_cnt2), 64'(cnt2));
    if (v) begin
      h = q[0];
      chk("out_alu_res", 64'(out_alu_res), 64'(h.alu));
      chk("out_data_mem", 64'(out_data_mem), 64'(h.dm));
      chk("out_dst", 64'(out_dst), 64'(h.dst));
      chk("out_mem_read_en", 64'(out_mem_read_en), 64'(h.mrd));
      chk("out_wb_en", 64'(out_wb_en), 64'(h.wb_en));
      chk("out_wb_value", 64'(out_wb_value), 64'(h.mrd ? h.dm : h.alu));
    end else begin
      chk("out_wb_en_idle", 64'(out_wb_en), 64'(0));
      if (clean) begin
        chk("idle_payload_zero",
            {out_alu_res, out_data_mem} | 64'({out_dst, out_mem_read_en, out_wb_value != 0}),
            64'(0));
      end
    end
  endtask

  // Called right after a falling edge with inputs already driven; returns on the next one.
  task automatic tick();
    bit   rdy, acc, pop, stall;
    ent_t e;
    #1;
    rdy   = (q.size() < 2) && !freeze && !flush;
    acc   = in_valid && rdy;
    pop   = (q.size() > 0) && out_ready && !freeze;
    stall = (q.size() > 0) && !out_ready;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    e = '{wb_en: in_wb_en, mrd: in_mem_read_en, alu: in_alu_res, dm: in_data_mem, dst: in_dst};
    @(posedge clk);
    if (flush) begin
      q.delete();
      clean = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        clean = 1'b0;
      end
    end
    if (clear_stats) begin
      cnt16 = 0;
      cnt2  = 0;
    end else if (stall) begin
      if (cnt16 < 65535) cnt16++;
      if (cnt2 < 3) cnt2++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [31:0] alu, input bit ordy, input bit frz = 0,
                       input bit fl = 0, input bit clr = 0, input bit mrd = 0,
                       input logic [31:0] dm = 32'h0, input bit wb = 1, input logic [3:0] dst = 4'h1);
    in_valid       = v;
    in_alu_res     = alu;
    in_data_mem    = dm;
    in_mem_read_en = mrd;
    in_wb_en       = wb;
    in_dst         = dst;
    out_ready      = ordy;
    freeze         = frz;
    flush          = fl;
    clear_stats    = clr;
    tick();
  endtask

  initial begin
    // Reset held with a valid input offered.
    in_valid = 1'b1;
    in_alu_res = 32'h55;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
    check_outputs();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_release_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);

    // Streaming: one beat per cycle, each visible one edge after acceptance.
    for (int i = 1; i <= 4; i++) begin
      drive(1, 32'(i), 1);
      chk("stream_alu", 64'(out_alu_res), 64'(i));
    end
    drive(0, 0, 1);

    // Back-pressure fills both entries.
    drive(1, 32'h11, 0);
    drive(1, 32'h22, 0);
    chk("bp_head", 64'(out_alu_res), 64'h11);
    drive(1, 32'h99, 0);
    chk("bp_full_ready", 64'(in_ready), 64'(0));
    chk("bp_cnt", 64'(stall_cnt), 64'(2));
    drive(0, 0, 1);
    chk("bp_second", 64'(out_alu_res), 64'h22);
    chk("bp_ready_back", 64'(in_ready), 64'(1));
    drive(0, 0, 1);

    // Freeze while holding one entry with both sides ready.
    drive(1, 32'h33, 0);
    repeat (3) begin
      drive(1, 32'h44, 1, 1);
      chk("frz_hold", 64'(out_alu_res), 64'h33);
    end
    drive(1, 32'h44, 1);
    chk("frz_resume", 64'(out_alu_res), 64'h44);
    drive(0, 0, 1);

    // Flush beats freeze and a concurrent valid input.
    drive(1, 32'hA1, 0);
    drive(1, 32'hA2, 0);
    drive(1, 32'hA3, 0, 1, 1);
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_alu", 64'(out_alu_res), 64'(0));
    drive(0, 0, 0);

    // Write-back mux and 2-bit counter saturation.
    drive(1, 32'hBEEF, 0, 0, 0, 0, 1, 32'hDEAD);
    chk("wb_mux", 64'(out_wb_value), 64'hDEAD);
    drive(0, 0, 0, 0, 0, 1);
    repeat (5) drive(0, 0, 0);
    chk("sat_cnt2", 64'(stall_cnt2), 64'(3));
    drive(0, 0, 0, 0, 0, 1);
    chk("clear_cnt", 64'(stall_cnt), 64'(0));

    // Asynchronous reset in the middle of a transfer.
    drive(1, 32'h77, 0);
    #2 rst = 1'b0;
    #1;
    q.delete();
    cnt16 = 0;
    cnt2  = 0;
    clean = 1'b1;
    chk("async_rst_valid", 64'(out_valid), 64'(0));
    chk("async_rst_cnt", 64'(stall_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    check_outputs();

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
            $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 49) == 0,
            1'($urandom), $urandom, 1'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
